// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//
// EX-stage consumer of fetch-time branch predictions. Each fetched branch
// pushes its prediction {pred_taken, pc, pred_target} into a small in-flight
// FIFO. When EX resolves a branch, the oldest entry is popped and compared
// against the real outcome. The unit then:
//   - strobes a predictor update (bp_update_valid / bp_update_taken),
//   - on a mispredict, pulses flush and redirect_valid with the correct
//     next PC, and spends one FLUSH cycle discarding everything in flight,
//   - counts resolved branches and mispredicts (saturating).
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   fetch_push          prediction valid this cycle
//   fetch_pred_taken    predicted direction
//   fetch_pc            PC of the fetched branch
//   fetch_pred_target   target used at fetch if predicted taken
//   fetch_stall         FIFO full, fetch must hold
//   ex_resolve          branch resolved in EX
//   ex_taken            actual direction
//   ex_target           actual taken target
//   bp_update_valid     predictor update strobe (1 cycle)
//   bp_update_taken     actual direction for the update
//   flush               kill IF/ID and ID/EX (1-cycle pulse)
//   redirect_valid      load redirect_pc into PC (1-cycle pulse)
//   redirect_pc         correct next PC (holds between mispredicts)
//   resolve_err         resolve seen with an empty FIFO (1-cycle pulse)
//   q_empty, q_full     FIFO status, decoded from the pointers
//   branch_count        resolved branches, saturating
//   mispredict_count    mispredicts, saturating
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_push,
    input  logic             fetch_pred_taken,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic [XLEN-1:0]  fetch_pred_target,
    output logic             fetch_stall,
    input  logic             ex_resolve,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             bp_update_valid,
    output logic             bp_update_taken,
    output logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             resolve_err,
    output logic             q_empty,
    output logic             q_full,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t state_reg;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    // Prediction storage. No reset: contents are only meaningful between
    // the pointers.
    logic            mem_taken  [DEPTH];
    logic [XLEN-1:0] mem_pc     [DEPTH];
    logic [XLEN-1:0] mem_target [DEPTH];

    logic             bp_update_valid_reg;
    logic             bp_update_taken_reg;
    logic             flush_reg;
    logic             redirect_valid_reg;
    logic [XLEN-1:0]  redirect_pc_reg;
    logic             resolve_err_reg;
    logic [CNT_W-1:0] branch_count_reg;
    logic [CNT_W-1:0] mispredict_count_reg;

    logic            in_run;
    logic            do_pop;
    logic            do_push;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic            head_taken;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_target;
    logic            mispredict;

    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];

    assign q_empty     = (wr_ptr_reg == rd_ptr_reg);
    assign q_full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign fetch_stall = q_full;

    // Everything presented during the FLUSH cycle is ignored.
    assign in_run  = (state_reg == ST_RUN);
    assign do_pop  = in_run && ex_resolve && !q_empty;
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    assign do_push = in_run && fetch_push && (!q_full || do_pop);

    assign head_taken  = mem_taken[rd_idx];
    assign head_pc     = mem_pc[rd_idx];
    assign head_target = mem_target[rd_idx];

    // Right direction but wrong target still counts as a mispredict.
    assign mispredict = (head_taken != ex_taken) ||
                        (head_taken && ex_taken && (head_target != ex_target));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_taken[wr_idx]  <= fetch_pred_taken;
            mem_pc[wr_idx]     <= fetch_pc;
            mem_target[wr_idx] <= fetch_pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg            <= ST_RUN;
            wr_ptr_reg           <= '0;
            rd_ptr_reg           <= '0;
            bp_update_valid_reg  <= 1'b0;
            bp_update_taken_reg  <= 1'b0;
            flush_reg            <= 1'b0;
            redirect_valid_reg   <= 1'b0;
            redirect_pc_reg      <= '0;
            resolve_err_reg      <= 1'b0;
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            bp_update_valid_reg <= 1'b0;
            flush_reg           <= 1'b0;
            redirect_valid_reg  <= 1'b0;
            resolve_err_reg     <= 1'b0;

            case (state_reg)
                ST_RUN: begin
                    if (do_push) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    end
                    if (do_pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    end
                    if (ex_resolve && q_empty) begin
                        resolve_err_reg <= 1'b1;
                    end
                    if (do_pop) begin
                        bp_update_valid_reg <= 1'b1;
                        bp_update_taken_reg <= ex_taken;
                        if (branch_count_reg != '1) begin
                            branch_count_reg <= branch_count_reg + CNT_ONE;
                        end
                        if (mispredict) begin
                            flush_reg          <= 1'b1;
                            redirect_valid_reg <= 1'b1;
                            redirect_pc_reg    <= ex_taken ? ex_target : (head_pc + PC_STEP);
                            if (mispredict_count_reg != '1) begin
                                mispredict_count_reg <= mispredict_count_reg + CNT_ONE;
                            end
                            state_reg <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Drop every in-flight prediction, including any pushed
                    // in the mispredict-resolve cycle.
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    state_reg  <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign bp_update_valid  = bp_update_valid_reg;
    assign bp_update_taken  = bp_update_taken_reg;
    assign flush            = flush_reg;
    assign redirect_valid   = redirect_valid_reg;
    assign redirect_pc      = redirect_pc_reg;
    assign resolve_err      = resolve_err_reg;
    assign branch_count     = branch_count_reg;
    assign mispredict_count = mispredict_count_reg;

endmodule
